// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for alu_mc.
package alu_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    // Opcodes that run on the iterative datapath rather than finishing in one cycle.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: one-bit-per-cycle logical shifts and unsigned shift-add multiply.
// result/carry/done reflect the step being taken this cycle, so the owner can
// register them on the same edge the final step completes.
module alu_iter import alu_pkg::*; #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [CNT_W-1:0] count,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic               carry_q, carry_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    // Next-state for load and for one shift / shift-add step.
    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        carry_d  = carry_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            op_d     = op;
            cnt_d    = count;
            val_d    = src_a;
            carry_d  = 1'b0;
            mcand_d  = {{WIDTH{1'b0}}, src_a};
            mplier_d = src_b;
            acc_d    = '0;
        end else if (step && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
            if (op_q == OP_MUL) begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            end else if (op_q == OP_SHL) begin
                carry_d = val_q[WIDTH-1];
                val_d   = {val_q[WIDTH-2:0], 1'b0};
            end else begin
                carry_d = val_q[0];
                val_d   = {1'b0, val_q[WIDTH-1:1]};
            end
        end
    end

    // A zero count still finishes on its single step cycle.
    always_comb begin
        done   = step && (cnt_q <= CNT_W'(1));
        result = (op_q == OP_MUL) ? acc_d[WIDTH-1:0] : val_d;
        carry  = (op_q == OP_MUL) ? (|acc_d[2*WIDTH-1:WIDTH]) : carry_d;
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= OP_NOT;
            cnt_q    <= '0;
            val_q    <= '0;
            carry_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            carry_q  <= carry_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/sub, iterative shifts and multiply,
// valid/ready handshake on both sides and registered {N,Z,C,V} flags.
module alu_mc import alu_pkg::*; #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic [3:0]       flags
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic [3:0]       flags_q, flags_d;

    logic             start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic             iter_carry;
    logic [CNT_W-1:0] iter_count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] fast_res;
    logic             fast_c;
    logic             fast_v;

    // Iteration count: shifts saturate at WIDTH, multiply always takes WIDTH steps.
    always_comb begin
        if ((select == OP_MUL) || (src2 >= W_VAL)) begin
            iter_count = CNT_W'(WIDTH);
        end else begin
            iter_count = src2[CNT_W-1:0];
        end
    end

    // Single-cycle result and carry/overflow for NOT/AND/OR/ADD/SUB.
    always_comb begin
        sum      = {1'b0, src1} + {1'b0, src2};
        diff     = {1'b0, src1} - {1'b0, src2};
        fast_res = '0;
        fast_c   = 1'b0;
        fast_v   = 1'b0;
        unique case (select)
            OP_NOT: fast_res = ~src1;
            OP_AND: fast_res = src1 & src2;
            OP_OR:  fast_res = src1 | src2;
            OP_ADD: begin
                fast_res = sum[WIDTH-1:0];
                fast_c   = sum[WIDTH];
                fast_v   = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                           (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res = diff[WIDTH-1:0];
                fast_c   = ~diff[WIDTH];  // no borrow
                fast_v   = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                           (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            default: fast_res = '0;
        endcase
    end

    // FSM next-state, handshake outputs and result/flag capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ans_d     = ans_q;
        flags_d   = flags_q;
        start     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d = select;
                    if (is_iter_op(select)) begin
                        start   = 1'b1;
                        state_d = StBusy;
                    end else begin
                        ans_d   = fast_res;
                        flags_d = {fast_res[WIDTH-1], fast_res == '0, fast_c, fast_v};
                        state_d = StDone;
                    end
                end
            end
            StBusy: begin
                if (iter_done) begin
                    ans_d   = iter_result;
                    flags_d = {iter_result[WIDTH-1], iter_result == '0, iter_carry,
                               (op_q == OP_MUL) && iter_carry};
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_NOT;
            ans_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ans_q   <= ans_d;
            flags_q <= flags_d;
        end
    end

    assign ans   = ans_q;
    assign flags = flags_q;

    alu_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .step   (state_q == StBusy),
        .op     (select),
        .src_a  (src1),
        .src_b  (src2),
        .count  (iter_count),
        .done   (iter_done),
        .result (iter_result),
        .carry  (iter_carry)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    select;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ans;
    logic [3:0]    flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans       (ans),
        .flags     (flags)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: result, {N,Z,C,V} and cycles from accept to out_valid.
    task automatic model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] f, output int lat);
        longint unsigned ua, ub, full;
        longint sa, sb, s;
        int    cnt;
        logic  c, v;
        ua = a; ub = b;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = 0; v = 0; lat = 1; full = 0;
        cnt = (ub > W) ? W : int'(ub);
        case (sel)
            3'b000: full = ~ua;
            3'b001: full = ua & ub;
            3'b010: full = ua | ub;
            3'b011: begin
                full = ua << cnt;
                c    = (cnt == 0) ? 1'b0 : 1'(ua >> (W - cnt));
                lat  = (cnt == 0) ? 2 : cnt + 1;
            end
            3'b100: begin
                full = ua >> cnt;
                c    = (cnt == 0) ? 1'b0 : 1'(ua >> (cnt - 1));
                lat  = (cnt == 0) ? 2 : cnt + 1;
            end
            3'b101: begin
                full = ua + ub;
                c    = (full >> W) != 0;
                s    = sa + sb;
                v    = (s > 32767) || (s < -32768);
            end
            3'b110: begin
                full = ua - ub;
                c    = ua >= ub;
                s    = sa - sb;
                v    = (s > 32767) || (s < -32768);
            end
            default: begin
                full = ua * ub;
                c    = (full >> W) != 0;
                v    = c;
                lat  = W + 1;
            end
        endcase
        r = W'(full);
        f = {r[W-1], r == 0, c, v};
    endtask

    // Issue one op from an idle negedge, check result/latency, hold in DONE, then retire it.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] e_ans;
        logic [3:0]   e_fl;
        int           e_lat;
        int           lat;
        model(sel, a, b, e_ans, e_fl, e_lat);
        check_eq({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1; select = sel; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 0; select = 3'($urandom); src1 = W'($urandom); src2 = W'($urandom);
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            in_valid = 1'($urandom); src1 = W'($urandom); src2 = W'($urandom);
        end
        in_valid = 0;
        check_eq({tag, "_latency"}, lat, e_lat);
        check_eq({tag, "_ans"}, ans, e_ans);
        check_eq({tag, "_flags"}, flags, e_fl);
        check_eq({tag, "_in_ready_done"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid; select = 3'($urandom); src1 = W'($urandom);
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_ready"}, in_ready, 0);
            check_eq({tag, "_hold_ans"}, ans, e_ans);
            check_eq({tag, "_hold_flags"}, flags, e_fl);
        end
        in_valid  = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        check_eq({tag, "_retired_valid"}, out_valid, 0);
        check_eq({tag, "_retired_ans"}, ans, e_ans);
        check_eq({tag, "_retired_flags"}, flags, e_fl);
    endtask

    initial begin
        int seen_valid;
        logic [2:0]   rs;
        logic [W-1:0] ra, rb;

        rst_n = 0; in_valid = 0; out_ready = 0; select = 0; src1 = 0; src2 = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_ans", ans, 0);
        check_eq("rst_flags", flags, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        run_op("add_ovf", 3'b101, 16'h7FFF, 16'h0001, 0);
        run_op("sub_zero", 3'b110, 16'h0005, 16'h0005, 0);
        run_op("sub_borrow", 3'b110, 16'h0000, 16'h0001, 0);
        run_op("shl_1", 3'b011, 16'h8001, 16'd1, 0);
        run_op("shr_20", 3'b100, 16'h00F0, 16'd20, 0);
        run_op("shl_0", 3'b011, 16'hA5C3, 16'd0, 0);
        run_op("shr_16", 3'b100, 16'h8000, 16'd16, 0);
        run_op("mul_ovf", 3'b111, 16'h0100, 16'h0100, 0);
        run_op("mul_3x5", 3'b111, 16'd3, 16'd5, 0);
        run_op("not", 3'b000, 16'h0F0F, 16'h0000, 0);
        run_op("hold5", 3'b001, 16'hF0F3, 16'h3F35, 5);

        // Reset in the middle of a multiply discards it.
        in_valid = 1; select = 3'b111; src1 = 16'd7; src2 = 16'd9;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check_eq("midmul_in_ready", in_ready, 1);
        check_eq("midmul_out_valid", out_valid, 0);
        check_eq("midmul_ans", ans, 0);
        check_eq("midmul_flags", flags, 0);
        seen_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1;
        end
        check_eq("midmul_discarded", seen_valid, 0);
        run_op("add_2_3", 3'b101, 16'd2, 16'd3, 0);

        for (int n = 0; n < 150; n++) begin
            rs = 3'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
            run_op("rand", rs, ra, rb, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 4..64).
REQ-002 SHALL have localparam CNT_W = clog2(WIDTH)+1, the iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand/opcode present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 select  input  3  opcode: 000 NOT, 001 AND, 010 OR, 011 SHL, 100 SHR, 101 ADD, 110 SUB, 111 MUL.
REQ-008 src1, src2  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result/flags held and valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ans  output  WIDTH  result.
REQ-012 flags  output  4  {N, Z, C, V}, registered with ans.

Function
REQ-013 SHALL accept an operation when in_valid && in_ready at a rising edge; operands and opcode SHALL be captured then, later input changes ignored.
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-015 IDLE: on accept, NOT/AND/OR/ADD/SUB SHALL go directly to DONE (out_valid asserted the cycle after accept, latency 1).
REQ-016 IDLE: on accept, SHL/SHR/MUL SHALL go to BUSY.
REQ-017 SHL/SHR SHALL shift one bit per BUSY cycle, logical (zero fill); count = min(src2, WIDTH); count 0 SHALL still spend exactly 1 BUSY cycle; out_valid at accept + count + 1 (min 2).
REQ-018 MUL SHALL be unsigned shift-add, exactly WIDTH BUSY cycles; out_valid at accept + WIDTH + 1; ans = low WIDTH bits of product.
REQ-019 DONE: out_valid = 1, ans/flags stable; on out_ready SHALL return to IDLE next cycle; no new accept in the same cycle as out_ready (throughput max one op per 2 cycles).
REQ-020 ADD: ans = (src1+src2) mod 2^WIDTH; C = carry out; V = signed overflow.
REQ-021 SUB: ans = (src1-src2) mod 2^WIDTH; C = 1 when no borrow (src1 >= src2 unsigned); V = signed overflow.
REQ-022 SHL/SHR: C = last bit shifted out (0 when count 0); V = 0.
REQ-023 MUL: C = V = 1 iff upper WIDTH product bits nonzero.
REQ-024 NOT/AND/OR: C = V = 0.
REQ-025 N = ans[WIDTH-1]; Z = (ans == 0), for every opcode.
REQ-026 in_valid while busy SHALL be ignored and not queued.
REQ-027 ans/flags SHALL hold last result after leaving DONE until next result is written.

Reset
REQ-028 rst_n low at a rising edge SHALL force IDLE, in_ready = 1, out_valid = 0, ans = 0, flags = 0, counter = 0, regardless of state (mid-BUSY op discarded, no out_valid).
REQ-029 After rst_n release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-030 Opcode constants (OP_NOT..OP_MUL) and FSM state encodings SHALL live in shared package alu_pkg.
REQ-031 Iterative shift/multiply datapath SHALL be one sub-module alu_iter (start, op, operands, count in; done, result, carry out); FSM and flag logic stay in alu_mc.

Verification
REQ-032 WIDTH=16, ADD 0x7FFF+0x0001 -> out_valid 1 cycle after accept, ans 0x8000, flags N=1 Z=0 C=0 V=1.
REQ-033 WIDTH=16, SUB 0x0005-0x0005 -> ans 0x0000, Z=1, C=1, V=0; SUB 0x0000-0x0001 -> ans 0xFFFF, N=1, C=0.
REQ-034 WIDTH=16, SHL 0x8001 by 1 -> ans 0x0002, C=1, latency 2; SHR 0x00F0 by 20 -> ans 0x0000, Z=1, latency 17; SHL by 0 -> ans unchanged, latency 2.
REQ-035 WIDTH=16, MUL 0x0100*0x0100 -> ans 0x0000, C=V=1, out_valid at accept+17; MUL 3*5 -> 0x000F, C=0.
REQ-036 Hold out_ready=0 for 5 cycles in DONE with in_valid toggling -> ans/flags/out_valid stable, in_ready 0, no second op accepted.
REQ-037 Assert rst_n=0 for one cycle mid-MUL -> next cycle IDLE, in_ready 1, out_valid 0, ans 0; new ADD 2+3 -> ans 5.
